// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Memory-stage load/store sequencer. Converts byte/halfword/word
//               requests into word-aligned bus transactions with a timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] rdata_aligned,
    output logic        rdata_valid,
    output logic        misaligned,
    output logic        bus_error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [15:0] c_cnt_last = 16'(ACK_TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_size;
    logic [1:0]  r_off;
    logic [15:0] r_cnt;

    logic        w_bad_align;
    logic        w_accept;
    logic        w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_rshift;

    // Alignment check, lane enables and store-data replication for the incoming request
    always_comb begin
        w_bad_align = 1'b0;
        w_be        = 4'b1111;
        w_wdata     = req_wdata;
        case (req_size)
            2'b10: begin
                w_be    = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_bad_align = req_addr[0];
                w_be        = 4'b0011 << {req_addr[1], 1'b0};
                w_wdata     = {2{req_wdata[15:0]}};
            end
            default: w_bad_align = |req_addr[1:0];
        endcase
    end

    always_comb begin
        w_rshift = mem_rdata;
        case (r_size)
            2'b10:   w_rshift = mem_rdata >> {r_off, 3'b000};
            2'b01:   w_rshift = mem_rdata >> {r_off[1], 4'b0000};
            default: w_rshift = mem_rdata;
        endcase
    end

    assign w_accept   = (r_state == ST_IDLE) && req_valid && !w_bad_align;
    assign w_timeout  = (r_state == ST_BUSY) && !mem_ack && (r_cnt == c_cnt_last);
    assign misaligned = (r_state == ST_IDLE) && req_valid && w_bad_align;
    assign stall      = w_accept || (r_state == ST_BUSY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_BUSY;
            ST_BUSY: if (mem_ack || w_timeout) w_state_nxt = ST_DONE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Bus-side fields stay frozen from acceptance until the next request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_be        <= '0;
            mem_wdata     <= '0;
            rdata_aligned <= '0;
            rdata_valid   <= 1'b0;
            bus_error     <= 1'b0;
            r_size        <= '0;
            r_off         <= '0;
            r_cnt         <= '0;
        end else begin
            rdata_valid <= 1'b0;
            bus_error   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        mem_req   <= 1'b1;
                        mem_we    <= req_we;
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        mem_be    <= w_be;
                        mem_wdata <= w_wdata;
                        r_size    <= req_size;
                        r_off     <= req_addr[1:0];
                        r_cnt     <= '0;
                    end
                end
                ST_BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            rdata_aligned <= w_rshift;
                            rdata_valid   <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        mem_req       <= 1'b0;
                        bus_error     <= 1'b1;
                        rdata_aligned <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed plus randomized bench for mem_access_unit against a
//               lane-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int ACK_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] rdata_aligned;
    logic        rdata_valid;
    logic        misaligned;
    logic        bus_error;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_access_unit #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stall        (stall),
        .rdata_aligned(rdata_aligned),
        .rdata_valid  (rdata_valid),
        .misaligned   (misaligned),
        .bus_error    (bus_error),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: byte lanes ----------------
    function automatic int nbytes(input logic [1:0] s);
        case (s)
            2'b10:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] s, input logic [31:0] a);
        logic [3:0] be = '0;
        int off = int'(a[1:0]);
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + nbytes(s)) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] s, input logic [31:0] d);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % nbytes(s)) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [31:0] a, input logic [31:0] d);
        return d >> (8 * int'(a[1:0]));
    endfunction

    function automatic bit model_misaligned(input logic [1:0] s, input logic [31:0] a);
        return (int'(a[1:0]) % nbytes(s)) != 0;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        check(tag, 32'(obs), 32'(exp));
    endtask

    task automatic check_i(input string tag, input int obs, input int exp);
        check(tag, 32'(obs), 32'(exp));
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    // One full request: request cycle, BUSY cycles, DONE cycle
    task automatic do_txn(input logic we, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int waits, input bit give_ack, output logic [31:0] got);
        int  stalls = 0;
        int  busy   = 0;
        bit  acked  = 0;
        bit  ended  = 0;
        to_drive();
        req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
        mem_ack = 1'b0;
        to_sample();
        check_b("req_stall", stall, 1'b1);
        check_b("req_misaligned", misaligned, 1'b0);
        check_b("req_mem_req", mem_req, 1'b0);
        check_b("req_bus_error", bus_error, 1'b0);
        check_b("req_rdata_valid", rdata_valid, 1'b0);
        stalls += int'(stall);
        for (int k = 0; k < 200 && !ended; k++) begin
            to_drive();
            req_valid = 1'($urandom); req_we = 1'($urandom); req_size = 2'($urandom);
            req_addr = $urandom; req_wdata = $urandom;
            mem_ack   = give_ack && (k == waits);
            mem_rdata = (k == waits) ? rdata : $urandom;
            to_sample();
            busy++;
            stalls += int'(stall);
            check_b("busy_mem_req", mem_req, 1'b1);
            check_b("busy_stall", stall, 1'b1);
            check_b("busy_misaligned", misaligned, 1'b0);
            check_b("busy_mem_we", mem_we, we);
            check("busy_mem_addr", mem_addr, {addr[31:2], 2'b00});
            check("busy_mem_be", 32'(mem_be), 32'(model_be(size, addr)));
            check("busy_mem_wdata", mem_wdata, model_wdata(size, wdata));
            check_b("busy_rdata_valid", rdata_valid, 1'b0);
            if (mem_ack) begin
                acked = 1;
                ended = 1;
            end else if (!give_ack && k == ACK_TIMEOUT - 1) begin
                ended = 1;
            end
        end
        check_b("busy_bound", ended, 1'b1);
        to_drive();
        mem_ack = 1'($urandom); mem_rdata = $urandom;
        req_valid = 1'b1; req_size = 2'b00; req_addr = $urandom | 32'h1;
        to_sample();
        stalls += int'(stall);
        check_b("done_mem_req", mem_req, 1'b0);
        check_b("done_stall", stall, 1'b0);
        check_b("done_misaligned", misaligned, 1'b0);
        check_b("done_rdata_valid", rdata_valid, !we && acked);
        check_b("done_bus_error", bus_error, !acked);
        if (!we && acked) check("done_rdata", rdata_aligned, model_rdata(addr, rdata));
        if (!acked)       check("timeout_rdata", rdata_aligned, 32'h0);
        check_i("stall_cycles", stalls, acked ? waits + 2 : ACK_TIMEOUT + 1);
        check_i("busy_cycles", busy, acked ? waits + 1 : ACK_TIMEOUT);
        got = rdata_aligned;
    endtask

    task automatic misalign_try(input logic [1:0] size, input logic [31:0] addr);
        to_drive();
        req_valid = 1'b1; req_we = 1'($urandom); req_size = size; req_addr = addr;
        req_wdata = $urandom; mem_ack = 1'b1;
        to_sample();
        check_b("mis_flag", misaligned, 1'b1);
        check_b("mis_stall", stall, 1'b0);
        check_b("mis_mem_req", mem_req, 1'b0);
        to_drive();
        req_valid = 1'b0; mem_ack = 1'b0;
        to_sample();
        check_b("mis_after_mem_req", mem_req, 1'b0);
        check_b("mis_after_stall", stall, 1'b0);
    endtask

    initial begin
        logic [31:0] got;
        logic [1:0]  sz;
        logic [31:0] ad;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        #12;
        check_b("rst_mem_req", mem_req, 1'b0);
        check_b("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_be", 32'(mem_be), 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_rdata", rdata_aligned, 32'h0);
        check_b("rst_rdata_valid", rdata_valid, 1'b0);
        check_b("rst_bus_error", bus_error, 1'b0);
        check_b("rst_stall", stall, 1'b0);
        to_drive();
        rst = 1'b0;

        // Byte load from lane 3
        do_txn(1'b0, 2'b10, 32'h0000_1003, 32'h0, 32'hA1B2_C3D4, 0, 1'b1, got);
        check("byte_load_value", got, 32'h0000_00A1);

        // Halfword store with three wait states
        do_txn(1'b1, 2'b01, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 3, 1'b1, got);

        misalign_try(2'b00, 32'h0000_3001);
        misalign_try(2'b01, 32'h0000_3003);

        // Timeout, then ack landing on the last possible BUSY cycle
        do_txn(1'b0, 2'b00, 32'h0000_5000, 32'h0, 32'h0, 0, 1'b0, got);
        do_txn(1'b0, 2'b00, 32'h0000_5004, 32'h0, 32'h1234_5678, ACK_TIMEOUT - 1, 1'b1, got);
        check("late_ack_value", got, 32'h1234_5678);

        // Reset in the 2nd BUSY cycle
        to_drive();
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_addr = 32'h0000_6000;
        to_drive();
        req_valid = 1'b0;
        to_drive();
        #1 rst = 1'b1;
        #1;
        check_b("mid_rst_mem_req", mem_req, 1'b0);
        check_b("mid_rst_stall", stall, 1'b0);
        to_drive();
        rst = 1'b0;
        do_txn(1'b0, 2'b00, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, 1, 1'b1, got);
        check("post_rst_value", got, 32'hCAFE_F00D);

        // Back-to-back word loads
        do_txn(1'b0, 2'b00, 32'h0000_0010, 32'h0, 32'h1111_2222, 0, 1'b1, got);
        check("b2b_first", got, 32'h1111_2222);
        do_txn(1'b0, 2'b00, 32'h0000_0014, 32'h0, 32'h3333_4444, 0, 1'b1, got);
        check("b2b_second", got, 32'h3333_4444);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            sz = 2'($urandom_range(0, 3));
            if (t % 5 == 4 && sz != 2'b10) begin
                ad = ($urandom & ~32'h3) | 32'($urandom_range(1, 3));
                if (sz == 2'b01) ad = ad | 32'h1;
                check_b("model_mis", 1'(model_misaligned(sz, ad)), 1'b1);
                misalign_try(sz, ad);
            end else begin
                ad = $urandom & ~32'(nbytes(sz) - 1);
                do_txn(1'($urandom), sz, ad, $urandom, $urandom,
                       int'($urandom_range(0, ACK_TIMEOUT - 1)),
                       $urandom_range(0, 7) != 0, got);
            end
        end

        to_drive();
        req_valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
